mips_multicycle_ctrl: RTL

Multicycle control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back, with wait states on a memory ready handshake. Drives the PC, IR, register-file and memory enables, and the immediate-routing select that steers the sign-extended immediate to the PC adder or the ALU. Sits between the instruction register and the datapath; it is the only source of datapath enables.

---
 rtl/mips_ctrl_pkg.sv | 16 +
 rtl/mips_op_class.sv | 20 ++
 rtl/mips_multicycle_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM states and opcode classes for the multicycle controller
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    typedef enum logic [2:0] {ST_IFETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_BRANCH} state_t;
    typedef enum logic [2:0] {CL_RTYPE, CL_IALU, CL_BRANCH, CL_LOAD, CL_STORE, CL_ILLEGAL} op_class_t;
endpackage

// File: rtl/mips_op_class.sv
// mips_op_class: combinational map from opcode to instruction class
module mips_op_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  op_class_o
);
    // anything not listed decodes as illegal
    always_comb begin
        op_class_o = CL_ILLEGAL;
        case (opcode_i)
            OP_RTYPE:                               op_class_o = CL_RTYPE;
            OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: op_class_o = CL_IALU;
            OP_B, OP_BEQ, OP_BNE:                   op_class_o = CL_BRANCH;
            OP_LW:                                  op_class_o = CL_LOAD;
            OP_SW:                                  op_class_o = CL_STORE;
            default:                                op_class_o = CL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory handshake and retired counter
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             Mem_ready,
    output logic             Instr_RdEn,
    output logic             IR_LdEn,
    output logic             PC_LdEn,
    output logic             PC_sel,
    output logic             Imm_route_pc,
    output logic             ALU_Bin_sel,
    output logic             RF_WrEn,
    output logic             RF_WrData_sel,
    output logic             Mem_RdEn,
    output logic             Mem_WrEn,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);
    state_t            state_q, state_d;
    op_class_t         class_q, dec_class;
    logic              imm_q, ill_q;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              fetch, ir_ld, pc_ld, pc_sel, bsel, rf_we, wd_sel, mrd, mwr, inc;

    mips_op_class u_class (.opcode_i(Opcode), .op_class_o(dec_class));

    // next state and datapath enables from state plus registered class
    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        ir_ld   = 1'b0;
        pc_ld   = 1'b0;
        pc_sel  = 1'b0;
        bsel    = 1'b0;
        rf_we   = 1'b0;
        wd_sel  = 1'b0;
        mrd     = 1'b0;
        mwr     = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IFETCH: begin
                fetch   = 1'b1;
                ir_ld   = Mem_ready;
                state_d = Mem_ready ? ST_DECODE : ST_IFETCH;
            end
            ST_DECODE: begin
                pc_ld   = dec_class == CL_ILLEGAL;
                state_d = dec_class == CL_ILLEGAL ? ST_IFETCH :
                          dec_class == CL_BRANCH  ? ST_BRANCH : ST_EXEC;
            end
            ST_EXEC: begin
                bsel    = class_q != CL_RTYPE;
                state_d = (class_q == CL_LOAD || class_q == CL_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                bsel    = 1'b1;
                mrd     = class_q == CL_LOAD;
                mwr     = class_q == CL_STORE;
                pc_ld   = mwr && Mem_ready;
                inc     = mwr && Mem_ready;
                state_d = !Mem_ready ? ST_MEM : mrd ? ST_WB : ST_IFETCH;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wd_sel  = class_q == CL_LOAD;
                pc_ld   = 1'b1;
                inc     = 1'b1;
                state_d = ST_IFETCH;
            end
            ST_BRANCH: begin
                pc_ld   = 1'b1;
                inc     = 1'b1;
                pc_sel  = Opcode == OP_B ? 1'b1 : Opcode == OP_BEQ ? Zero : !Zero;
                state_d = ST_IFETCH;
            end
            default: state_d = ST_IFETCH;
        endcase
    end

    assign ret_d = inc ? ret_q + CNT_W'(1) : ret_q;

    // state, class/route capture at DECODE, sticky illegal flag and retired count
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IFETCH;
            class_q <= CL_RTYPE;
            imm_q   <= 1'b0;
            ill_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ill_q   <= ill_q | (state_q == ST_DECODE && dec_class == CL_ILLEGAL);
            if (state_q == ST_DECODE) begin
                class_q <= dec_class;
                imm_q   <= dec_class == CL_BRANCH;
            end
        end
    end

    assign Instr_RdEn    = Rst_n & fetch;
    assign IR_LdEn       = Rst_n & ir_ld;
    assign PC_LdEn       = Rst_n & pc_ld;
    assign PC_sel        = Rst_n & pc_sel;
    assign Imm_route_pc  = Rst_n & imm_q;
    assign ALU_Bin_sel   = Rst_n & bsel;
    assign RF_WrEn       = Rst_n & rf_we;
    assign RF_WrData_sel = Rst_n & wd_sel;
    assign Mem_RdEn      = Rst_n & mrd;
    assign Mem_WrEn      = Rst_n & mwr;
    assign Illegal       = Rst_n & ill_q;
    assign Retired       = Rst_n ? ret_q : '0;
endmodule
